// File: rtl/regfile_write_scheduler.sv
// Round-robin scheduler driving the two write ports of the dual-write RegisterFile.
// Optional: define REG0_DISCARD_EN to absorb writes to register 0 without a port.
module regfile_write_scheduler #(
   parameter int NREQ = 4,
   parameter int AW   = 5,
   parameter int DW   = 32,
   parameter int CW   = 16
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   input  logic                 Stall,
   input  logic [NREQ-1:0]      ReqValid,
   output logic [NREQ-1:0]      ReqReady,
   input  logic [NREQ*AW-1:0]   ReqReg,
   input  logic [NREQ*DW-1:0]   ReqData,
   output logic                 RegWrite1,
   output logic [AW-1:0]        WriteRegister1,
   output logic [DW-1:0]        WriteData1,
   output logic                 RegWrite2,
   output logic [AW-1:0]        WriteRegister2,
   output logic [DW-1:0]        WriteData2,
   output logic [CW-1:0]        ConflictCount
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rw1_q, rw2_q;
   logic [AW-1:0] wr1_q, wr2_q;
   logic [DW-1:0] wd1_q, wd2_q;

   logic          ga, gb, defer;
   logic [AW-1:0] reg_a, reg_b;
   logic [DW-1:0] dat_a, dat_b;

   always_comb begin
      int idx;
      int last;
      ReqReady = '0;
      ga       = 1'b0;
      gb       = 1'b0;
      defer    = 1'b0;
      reg_a    = '0;
      reg_b    = '0;
      dat_a    = '0;
      dat_b    = '0;
      ptr_d    = ptr_q;
      idx      = 0;
      last     = 0;
      if (!Stall) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (ReqValid[idx]) begin
`ifdef REG0_DISCARD_EN
               if (ReqReg[idx*AW +: AW] == '0) begin
                  ReqReady[idx] = 1'b1;
               end else
`endif
               if (!ga) begin
                  ga            = 1'b1;
                  reg_a         = ReqReg[idx*AW +: AW];
                  dat_a         = ReqData[idx*DW +: DW];
                  last          = idx;
                  ReqReady[idx] = 1'b1;
               end else if (!gb) begin
                  // Same destination as port 1 must wait a cycle.
                  if (ReqReg[idx*AW +: AW] != reg_a) begin
                     gb            = 1'b1;
                     reg_b         = ReqReg[idx*AW +: AW];
                     dat_b         = ReqData[idx*DW +: DW];
                     last          = idx;
                     ReqReady[idx] = 1'b1;
                  end else begin
                     defer = 1'b1;
                  end
               end
            end
         end
         if (ga) ptr_d = PW'((last + 1) % NREQ);
      end
   end

   assign cnt_d = (defer && (cnt_q != {CW{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         ptr_q <= '0;
         cnt_q <= '0;
         rw1_q <= 1'b0;
         rw2_q <= 1'b0;
         wr1_q <= '0;
         wr2_q <= '0;
         wd1_q <= '0;
         wd2_q <= '0;
      end else begin
         rw1_q <= ga;
         rw2_q <= gb;
         if (ga) begin
            wr1_q <= reg_a;
            wd1_q <= dat_a;
         end
         if (gb) begin
            wr2_q <= reg_b;
            wd2_q <= dat_b;
         end
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   assign RegWrite1      = rw1_q;
   assign WriteRegister1 = wr1_q;
   assign WriteData1     = wd1_q;
   assign RegWrite2      = rw2_q;
   assign WriteRegister2 = wr2_q;
   assign WriteData2     = wd2_q;
   assign ConflictCount  = cnt_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Scoreboard bench for regfile_write_scheduler against a queue-based model.
module tb_regfile_write_scheduler;

   localparam int NREQ = 4;
   localparam int AW   = 5;
   localparam int DW   = 32;
   localparam int CW   = 16;

   logic                Clk = 1'b0;
   logic                Reset_n;
   logic                Stall;
   logic [NREQ-1:0]     ReqValid;
   logic [NREQ-1:0]     ReqReady;
   logic [NREQ*AW-1:0]  ReqReg;
   logic [NREQ*DW-1:0]  ReqData;
   logic                RegWrite1, RegWrite2;
   logic [AW-1:0]       WriteRegister1, WriteRegister2;
   logic [DW-1:0]       WriteData1, WriteData2;
   logic [CW-1:0]       ConflictCount;

   regfile_write_scheduler #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(CW)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Stall(Stall),
      .ReqValid(ReqValid), .ReqReady(ReqReady),
      .ReqReg(ReqReg), .ReqData(ReqData),
      .RegWrite1(RegWrite1), .WriteRegister1(WriteRegister1),
      .WriteData1(WriteData1),
      .RegWrite2(RegWrite2), .WriteRegister2(WriteRegister2),
      .WriteData2(WriteData2),
      .ConflictCount(ConflictCount)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic          rw1;
      logic [AW-1:0] r1;
      logic [DW-1:0] d1;
      logic          rw2;
      logic [AW-1:0] r2;
      logic [DW-1:0] d2;
      logic [CW-1:0] cc;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Requester-side state and model state
   logic          pend[NREQ];
   logic [AW-1:0] preg[NREQ];
   logic [DW-1:0] pdat[NREQ];
   int            m_ptr;
   int            m_cc;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit any_pend();
      bit r = 0;
      for (int i = 0; i < NREQ; i++) if (pend[i]) r = 1;
      return r;
   endfunction

   task automatic load(input int i, input int r, input logic [DW-1:0] d);
      pend[i] = 1'b1;
      preg[i] = AW'(r);
      pdat[i] = d;
   endtask

   // One cycle: drive held requests, predict grants, queue the port writes.
   task automatic step(input bit stall, output logic [NREQ-1:0] rdy);
      int   ord[$];
      int   a, b;
      bit   conf;
      exp_t e;
      logic [NREQ-1:0] exp_rdy;
      @(negedge Clk);
      Stall = stall;
      for (int i = 0; i < NREQ; i++) begin
         ReqValid[i]          = pend[i];
         ReqReg[i*AW +: AW]   = preg[i];
         ReqData[i*DW +: DW]  = pdat[i];
      end
      #1;
      exp_rdy = '0;
      a = -1;
      b = -1;
      conf = 0;
      if (!stall) begin
         for (int k = 0; k < NREQ; k++) begin
            int i = (m_ptr + k) % NREQ;
            if (pend[i]) begin
`ifdef REG0_DISCARD_EN
               if (preg[i] == '0) exp_rdy[i] = 1'b1;
               else ord.push_back(i);
`else
               ord.push_back(i);
`endif
            end
         end
         if (ord.size() > 0) a = ord[0];
         for (int j = 1; j < ord.size(); j++) begin
            if (b < 0) begin
               if (preg[ord[j]] != preg[a]) b = ord[j];
               else conf = 1;
            end
         end
      end
      e = '{default: '0};
      if (a >= 0) begin
         exp_rdy[a] = 1'b1;
         e.rw1 = 1'b1;
         e.r1  = preg[a];
         e.d1  = pdat[a];
         m_ptr = (a + 1) % NREQ;
      end
      if (b >= 0) begin
         exp_rdy[b] = 1'b1;
         e.rw2 = 1'b1;
         e.r2  = preg[b];
         e.d2  = pdat[b];
         m_ptr = (b + 1) % NREQ;
      end
      if (conf && m_cc < (1 << CW) - 1) m_cc++;
      e.cc = CW'(m_cc);
      rdy = ReqReady;
      chk("ReqReady", 64'(ReqReady), 64'(exp_rdy));
      for (int i = 0; i < NREQ; i++) if (exp_rdy[i]) pend[i] = 1'b0;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      logic [NREQ-1:0] r;
      for (int c = 0; c < 50 && any_pend(); c++) step(1'b0, r);
      if (any_pend()) chk("drain bound", 64'(1), 64'(0));
      step(1'b0, r);
   endtask

   // Monitor: compares the registered write ports each cycle.
   initial begin
      exp_t e;
      forever begin
         @(posedge Clk);
         #1;
         if (Reset_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("RegWrite1", 64'(RegWrite1), 64'(e.rw1));
            chk("RegWrite2", 64'(RegWrite2), 64'(e.rw2));
            if (e.rw1) begin
               chk("WriteRegister1", 64'(WriteRegister1), 64'(e.r1));
               chk("WriteData1", 64'(WriteData1), 64'(e.d1));
            end
            if (e.rw2) begin
               chk("WriteRegister2", 64'(WriteRegister2), 64'(e.r2));
               chk("WriteData2", 64'(WriteData2), 64'(e.d2));
            end
            chk("ConflictCount", 64'(ConflictCount), 64'(e.cc));
            if (RegWrite1 && RegWrite2)
               chk("ports distinct", 64'(WriteRegister1 != WriteRegister2), 64'(1));
         end
      end
   end

   initial begin
      logic [NREQ-1:0] r;
      int gcnt[NREQ];
      Reset_n  = 1'b0;
      Stall    = 1'b0;
      ReqValid = '0;
      ReqReg   = '0;
      ReqData  = '0;
      m_ptr    = 0;
      m_cc     = 0;
      for (int i = 0; i < NREQ; i++) begin
         pend[i] = 1'b0;
         preg[i] = '0;
         pdat[i] = '0;
         gcnt[i] = 0;
      end
      #12;
      chk("reset RegWrite1", 64'(RegWrite1), 64'(0));
      chk("reset RegWrite2", 64'(RegWrite2), 64'(0));
      chk("reset ConflictCount", 64'(ConflictCount), 64'(0));
      @(negedge Clk);
      Reset_n = 1'b1;

      // Four distinct destinations from Ptr=0
      load(0, 3, 32'hA0);
      load(1, 7, 32'hA1);
      load(2, 9, 32'hA2);
      load(3, 12, 32'hA3);
      step(1'b0, r);
      chk("t2 cycle1 ready", 64'(r), 64'(4'b0011));
      step(1'b0, r);
      chk("t2 cycle2 ready", 64'(r), 64'(4'b1100));
      step(1'b0, r);

      // Same destination from two requesters
      load(0, 5, 32'h11);
      load(1, 5, 32'h22);
      step(1'b0, r);
      chk("t3 cycle1 ready", 64'(r), 64'(4'b0001));
      step(1'b0, r);
      chk("t3 cycle2 ready", 64'(r), 64'(4'b0010));
      step(1'b0, r);

      // Continuous load, distinct registers
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < NREQ; i++)
            if (!pend[i]) load(i, 8 + i, $urandom);
         step(1'b0, r);
         for (int i = 0; i < NREQ; i++) gcnt[i] += int'(r[i]);
      end
      for (int i = 0; i < NREQ; i++)
         chk($sformatf("t4 grants req%0d", i), 64'(gcnt[i]), 64'(4));
      drain();

      // Stall with everyone waiting
      for (int i = 0; i < NREQ; i++) load(i, 16 + i, $urandom);
      repeat (3) begin
         step(1'b1, r);
         chk("stall ready", 64'(r), 64'(0));
      end
      drain();

      // Random traffic with frequent register collisions
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++)
            if (!pend[i] && $urandom_range(1, 0) == 1)
               load(i, int'($urandom_range(7, 0)), $urandom);
         step($urandom_range(7, 0) == 0, r);
      end
      drain();

      // Reset while writes are registered
      for (int i = 0; i < NREQ; i++) load(i, 20 + i, $urandom);
      step(1'b0, r);
      @(posedge Clk);
      #2;
      Reset_n = 1'b0;
      #1;
      chk("midreset RegWrite1", 64'(RegWrite1), 64'(0));
      chk("midreset RegWrite2", 64'(RegWrite2), 64'(0));
      chk("midreset WriteRegister1", 64'(WriteRegister1), 64'(0));
      chk("midreset WriteData2", 64'(WriteData2), 64'(0));
      chk("midreset ConflictCount", 64'(ConflictCount), 64'(0));
      exp_q.delete();
      m_ptr = 0;
      m_cc  = 0;
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b1;
      step(1'b0, r);
      step(1'b0, r);
      load(2, 6, 32'h66);
      load(3, 6, 32'h77);
      step(1'b0, r);
      chk("post-reset ptr0 ready", 64'(r), 64'(4'b0100));
      drain();

      repeat (2) @(posedge Clk);
      #2;
      chk("scoreboard empty", 64'(exp_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
